led_pattern_gen: RTL

Parametrised LED pattern engine for the board LED bank. Generates several selectable animation patterns over N_LEDS active-low outputs. Pattern steps are paced by a programmable clock prescaler instead of stepping every iclk edge. It sits between board top-level control (switches or register bits) and the LED pins.

---
 rtl/led_pkg.sv | 17 +
 rtl/led_tick_gen.sv | 34 +++
 rtl/led_pattern_gen.sv | 117 +++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings and default widths.
package led_pkg;

  localparam int unsigned MODE_W     = 3;
  localparam int unsigned N_LEDS_DEF = 4;
  localparam int unsigned DIV_W_DEF  = 24;
  localparam int unsigned PWM_W_DEF  = 4;

  typedef enum logic [MODE_W-1:0] {
    MODE_ROT_L  = 3'd0,
    MODE_ROT_R  = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_COUNT  = 3'd3,
    MODE_BLINK  = 3'd4
  } mode_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: emits a one-cycle step strobe every div+1 enabled cycles.
module led_tick_gen #(
  parameter int unsigned DIV_W = 24
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             step
);

  logic [DIV_W-1:0] cnt;
  logic             armed;

  // armed keeps the first edge after reset release from counting or stepping
  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (clr) begin
        cnt <= '0;
      end else if (en && armed) begin
        if (cnt >= div) cnt <= '0;
        else            cnt <= cnt + DIV_W'(1);
      end
    end
  end

  assign step = en && armed && !clr && (cnt >= div);

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine with prescaled stepping and active-low outputs.
// Optional brightness PWM is enabled by defining LED_DIM_EN.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS = N_LEDS_DEF,
  parameter int unsigned DIV_W  = DIV_W_DEF,
  parameter int unsigned PWM_W  = PWM_W_DEF
) (
  input  logic              iclk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [DIV_W-1:0]  div,
`ifdef LED_DIM_EN
  input  logic [PWM_W-1:0]  duty,
`endif
  output logic              tick,
  output logic [N_LEDS-1:0] leds
);

  if (N_LEDS < 2 || PWM_W < 1) begin : g_bad_param
    $error("led_pattern_gen: N_LEDS must be >= 2 and PWM_W >= 1");
  end

  logic [N_LEDS-1:0] pat;
  logic              dir;
  logic [MODE_W-1:0] mode_q;
  logic              mode_chg;
  logic              step;
  logic              tick_s;

  assign mode_chg = (mode != mode_q);

  led_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .iclk (iclk),
    .rst  (rst),
    .en   (en),
    .clr  (mode_chg),
    .div  (div),
    .step (step)
  );

  // Reseed uses the incoming mode; stepping uses the registered mode.
  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      pat    <= N_LEDS'(1);
      dir    <= 1'b0;
      mode_q <= MODE_ROT_L;
      tick_s <= 1'b0;
    end else begin
      mode_q <= mode;
      tick_s <= step;
      if (mode_chg) begin
        case (mode)
          MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE: begin
            pat <= N_LEDS'(1);
            dir <= 1'b0;
          end
          MODE_COUNT: pat <= '0;
          MODE_BLINK: pat <= '1;
          default: ;
        endcase
      end else if (step) begin
        case (mode_q)
          MODE_ROT_L: pat <= {pat[N_LEDS-2:0], pat[N_LEDS-1]};
          MODE_ROT_R: pat <= {pat[0], pat[N_LEDS-1:1]};
          MODE_BOUNCE: begin
            // end LEDs turn around immediately so they are shown only once
            if (!dir) begin
              if (pat[N_LEDS-1]) begin
                dir <= 1'b1;
                pat <= pat >> 1;
              end else begin
                pat <= pat << 1;
              end
            end else begin
              if (pat[0]) begin
                dir <= 1'b0;
                pat <= pat << 1;
              end else begin
                pat <= pat >> 1;
              end
            end
          end
          MODE_COUNT: pat <= pat + N_LEDS'(1);
          MODE_BLINK: pat <= ~pat;
          default: ;
        endcase
      end
    end
  end

`ifdef LED_DIM_EN
  logic [PWM_W-1:0] pwm;
  logic             lit_mask;

  assign lit_mask = (pwm < duty) || (duty == '1);

  // Registered output adds one cycle, so tick is delayed to stay aligned.
  always_ff @(posedge iclk or negedge rst) begin
    if (!rst) begin
      pwm  <= '0;
      leds <= ~N_LEDS'(1);
      tick <= 1'b0;
    end else begin
      pwm  <= pwm + PWM_W'(1);
      leds <= ~(pat & {N_LEDS{lit_mask}});
      tick <= tick_s;
    end
  end
`else
  assign leds = ~pat;
  assign tick = tick_s;
`endif

endmodule
